// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one SPI MOSI shifter between NREQ byte sources.
// Define SPI_ARB_PRIO_EN to make requester 0 a fixed high-priority client.
module spi_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int LEN_W     = 4,
  parameter int SETUP_CYC = 2,
  parameter int GAP_CYC   = 3,
  localparam int ID_W     = $clog2(NREQ)
) (
  input  logic                    m_clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEN_W-1:0]   req_len,
  input  logic [NREQ*8-1:0]       req_data,
  output logic [NREQ-1:0]         data_take,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic                    tx_done,
  output logic [NREQ-1:0]         spi_cs_n,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy,
  output logic [2:0]              state_dbg
);

  // Handshake: a byte moves when tx_valid & tx_ready are both high on a
  // rising edge; tx_valid never depends on tx_ready.

  localparam int CMAX = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam logic [ID_W:0]   NREQ_X  = (ID_W+1)'(NREQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;

  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [ID_W:0]    cand;
  logic             xfer_act;
  logic             cs_act;

  // Search starts at rr_ptr and wraps modulo NREQ (NREQ need not be a power of two).
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (cand >= NREQ_X) cand = cand - NREQ_X;
      if (!win_found && req[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
`ifdef SPI_ARB_PRIO_EN
    if (req[0]) begin
      win_found = 1'b1;
      win_id    = '0;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    tmr_d      = tmr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d    = win_id;
          byte_cnt_d = req_len[int'(win_id)*LEN_W +: LEN_W];
          tmr_d      = CNT_W'(SETUP_CYC - 1);
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_q == '0) state_d = ST_XFER;
        else             tmr_d   = tmr_q - 1'b1;
      end
      ST_XFER: begin
        if (tx_ready) begin
          if (byte_cnt_q == '0) state_d    = ST_DRAIN;
          else                  byte_cnt_d = byte_cnt_q - 1'b1;
        end
      end
      ST_DRAIN: begin
        if (tx_done) begin
          tmr_d   = CNT_W'(GAP_CYC - 1);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_q == '0) begin
          state_d = ST_IDLE;
`ifdef SPI_ARB_PRIO_EN
          if (grant_q != '0)
            rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
`else
          rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
`endif
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge m_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      tmr_q      <= tmr_d;
    end
  end

  // Outputs are gated by rst so chip select releases within the reset cycle itself.
  always_comb begin
    xfer_act  = (state_q == ST_XFER) && !rst;
    cs_act    = ((state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_DRAIN)) && !rst;
    tx_valid  = xfer_act;
    tx_data   = xfer_act ? req_data[int'(grant_q)*8 +: 8] : 8'h00;
    data_take = '0;
    if (xfer_act && tx_ready) data_take[grant_q] = 1'b1;
    spi_cs_n  = '1;
    if (cs_act) spi_cs_n[grant_q] = 1'b0;
    busy      = (state_q != ST_IDLE) && !rst;
    grant_id  = grant_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed + randomized bench for spi_tx_arbiter against a frame-level reference
// model (grant order, byte stream, chip-select/valid timing per cycle).
module tb_spi_tx_arbiter;
  localparam int NREQ = 4;
  localparam int LEN_W = 4;
  localparam int SETUP_CYC = 2;
  localparam int GAP_CYC = 3;

  logic        m_clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [31:0] req_data;
  logic [3:0]  data_take;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_done;
  logic [3:0]  spi_cs_n;
  logic [1:0]  grant_id;
  logic        busy;
  logic [2:0]  state_dbg;

  spi_tx_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W), .SETUP_CYC(SETUP_CYC), .GAP_CYC(GAP_CYC)) dut (
    .m_clk(m_clk), .rst(rst), .req(req), .req_len(req_len), .req_data(req_data),
    .data_take(data_take), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .spi_cs_n(spi_cs_n), .grant_id(grant_id), .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 m_clk = ~m_clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         m_rr = 0;
  logic [3:0] len_a[4];
  logic [7:0] base_a[4];
  logic [7:0] take_a[4];
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge m_clk);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_len[i*4 +: 4]  = len_a[i];
      req_data[i*8 +: 8] = base_a[i] + take_a[i];
    end
  endtask

  // Reference arbitration: fixed priority for 0 (optional), else first set bit from m_rr upward.
  function automatic int predict(input logic [3:0] mask);
    int w;
    w = -1;
`ifdef SPI_ARB_PRIO_EN
    if (mask[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && mask[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
    return w;
  endfunction

  // Starts and ends at posedge+1 of an IDLE cycle.
  task automatic do_frame(input logic [3:0] mask, input int rmode, input int done_dly,
                          input int drop_after);
    int         w, nbytes, sent, cyc;
    logic       r;
    logic [3:0] cs_exp, one_hot;
    w       = predict(mask);
    nbytes  = int'(len_a[w]) + 1;
    cs_exp  = ~(4'b0001 << w);
    one_hot = 4'b0001 << w;
    for (int k = 0; k < nbytes; k++) exp_q.push_back(base_a[w] + take_a[w] + 8'(k));
    req = mask; tx_ready = 1'b1; tx_done = 1'b0; drive(); #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_cs", 32'(spi_cs_n), 32'hF);
    for (int s = 0; s < SETUP_CYC; s++) begin
      step();
      tx_ready = 1'($urandom_range(0, 1));
      if (s == 0) len_a[w] = 4'($urandom_range(0, 15));
      drive(); #1;
      chk("setup_cs", 32'(spi_cs_n), 32'(cs_exp));
      chk("setup_valid", 32'(tx_valid), 0);
      chk("setup_take", 32'(data_take), 0);
      if (s == 0) begin
        chk("grant_id", 32'(grant_id), w);
        chk("setup_busy", 32'(busy), 1);
      end
    end
    sent = 0; cyc = 0;
    while (sent < nbytes && cyc < 80) begin
      step();
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      tx_ready = r;
      tx_done  = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (drop_after >= 0 && sent == drop_after) req[2'(w)] = 1'b0;
      drive(); #1;
      chk("xfer_valid", 32'(tx_valid), 1);
      chk("xfer_cs", 32'(spi_cs_n), 32'(cs_exp));
      chk("xfer_data", 32'(tx_data), 32'(exp_q[0]));
      chk("xfer_take", 32'(data_take), r ? 32'(one_hot) : 0);
      if (r) begin
        void'(exp_q.pop_front());
        take_a[w] = take_a[w] + 8'd1;
        sent++;
      end
      cyc++;
    end
    chk("xfer_bytes", sent, nbytes);
    for (int k = 1; k <= done_dly; k++) begin
      step();
      tx_ready = 1'($urandom_range(0, 1));
      tx_done  = (k == done_dly);
      drive(); #1;
      chk("drain_valid", 32'(tx_valid), 0);
      chk("drain_take", 32'(data_take), 0);
      chk("drain_cs", 32'(spi_cs_n), 32'(cs_exp));
    end
    for (int g = 0; g < GAP_CYC; g++) begin
      step();
      tx_done = 1'b0; tx_ready = 1'($urandom_range(0, 1)); drive(); #1;
      chk("gap_cs", 32'(spi_cs_n), 32'hF);
      chk("gap_busy", 32'(busy), 1);
      chk("gap_take", 32'(data_take), 0);
    end
`ifdef SPI_ARB_PRIO_EN
    if (w != 0) m_rr = (w + 1) % NREQ;
`else
    m_rr = (w + 1) % NREQ;
`endif
    step();
    tx_done = 1'b0; drive();
  endtask

  initial begin
    rst = 1'b1; req = '0; tx_ready = 1'b0; tx_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      len_a[i]  = '0;
      base_a[i] = 8'($urandom_range(0, 255));
      take_a[i] = '0;
    end
    drive();
    step(); step(); #1;
    chk("rst_cs", 32'(spi_cs_n), 32'hF);
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_take", 32'(data_take), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    step(); rst = 1'b0;

    // no requests: bus stays idle
    for (int c = 0; c < 20; c++) begin
      step(); #1;
      chk("quiet_cs", 32'(spi_cs_n), 32'hF);
      chk("quiet_busy", 32'(busy), 0);
      chk("quiet_valid", 32'(tx_valid), 0);
    end

    // all requesting, single-byte frames: rotation (or requester 0 repeatedly)
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 4; i++) len_a[i] = '0;
      do_frame(4'b1111, 0, 2, -1);
    end

    len_a[2] = 4'd2;
    do_frame(4'b0100, 0, 8, -1);

    len_a[0] = 4'd3;
    do_frame(4'b0001, 1, 3, -1);

    len_a[1] = 4'd5;
    do_frame(4'b0010, 0, 2, 2);

    len_a[3] = 4'd15;
    do_frame(4'b1000, 2, 4, -1);

    len_a[2] = 4'd1;
    do_frame(4'b0100, 0, 1, -1);

    // reset mid-frame with three bytes still owed after the current one
    req = 4'b0010; len_a[1] = 4'd3; tx_ready = 1'b0; drive();
    step(); step(); step(); #1;
    chk("pre_rst_valid", 32'(tx_valid), 1);
    step();
    rst = 1'b1; tx_ready = 1'b1; #1;
    chk("rstcyc_take", 32'(data_take), 0);
    chk("rstcyc_cs", 32'(spi_cs_n), 32'hF);
    step();
    rst = 1'b0; req = '0; tx_ready = 1'b0; #1;
    chk("post_rst_cs", 32'(spi_cs_n), 32'hF);
    chk("post_rst_valid", 32'(tx_valid), 0);
    chk("post_rst_busy", 32'(busy), 0);
    m_rr = 0;
    exp_q.delete();
    len_a[1] = 4'd0; len_a[3] = 4'd0;
    do_frame(4'b1010, 0, 1, -1);

    // randomized frames
    for (int f = 0; f < 14; f++) begin
      logic [3:0] mask;
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) len_a[i] = 4'($urandom_range(0, 15));
      do_frame(mask, 2, $urandom_range(1, 5), ($urandom_range(0, 3) == 0) ? 1 : -1);
    end

    req = '0; drive();
    step(); #1;
    chk("final_busy", 32'(busy), 0);
    chk("final_cs", 32'(spi_cs_n), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_tx_arbiter.md
# spi_tx_arbiter

Round-robin transmit controller that shares the single SPI MOSI shifter between NREQ requesters. It grants one requester per frame, drives that requester's chip select, and streams its bytes to the shifter over a valid/ready handshake. It releases the bus only after the shifter reports the last bit sent. It sits between the per-client byte sources and the SPI shifter/clock-divider pair, all on `m_clk`.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `LEN_W`, 4: width of each frame-length field; frame length is len+1 bytes.
- `SETUP_CYC`, 2: cycles chip select is held low before the first byte is offered (≥1).
- `GAP_CYC`, 3: cycles chip select is held high after a frame before the next grant (≥1).

- `m_clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester frame request, level.
- `req_len`  in  NREQ*LEN_W  packed frame length−1; slice i belongs to requester i.
- `req_data`  in  NREQ*8  packed current byte; slice i belongs to requester i.
- `data_take`  out  NREQ  one-cycle pulse to owner when its byte is accepted by the shifter.
- `tx_data`  out  8  byte to shifter.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  shifter accepts byte when `tx_valid & tx_ready`.
- `tx_done`  in  1  shifter pulse: last bit of the accepted byte has left MOSI.
- `spi_cs_n`  out  NREQ  active-low chip selects, at most one low.
- `grant_id`  out  $clog2(NREQ)  index of the current owner.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SETUP, XFER, DRAIN, GAP.
- IDLE: if any `req` is high, select the winner by round-robin from pointer `rr_ptr`. The search covers indices rr_ptr, rr_ptr+1, … mod NREQ. Latch `grant_id` and the winner's `req_len` into `byte_cnt`. Go to SETUP.
- SETUP: `spi_cs_n[grant_id]`=0. Count SETUP_CYC cycles, then go to XFER.
- XFER: `tx_valid`=1 and `tx_data`=`req_data[grant_id]`, combinational from the granted slice. On each handshake, pulse `data_take[grant_id]`.
  - If `byte_cnt`≠0, decrement it and stay in XFER.
  - If `byte_cnt`=0, go to DRAIN with `tx_valid`=0 the next cycle.
- DRAIN: hold chip select low and wait for `tx_done`, then go to GAP. A `tx_done` seen in XFER is ignored.
- GAP: all `spi_cs_n`=1. Count GAP_CYC cycles. `rr_ptr` ← grant_id+1 mod NREQ. Go to IDLE.
- Once granted, a frame always completes:
  - Deasserting `req` mid-frame has no effect.
  - `req_len` changes after the grant are ignored.
- `tx_ready` high outside XFER is ignored.
- `byte_cnt` is LEN_W bits wide; len = 2^LEN_W−1 gives 2^LEN_W bytes and does not wrap.

## Timing
- Reset values: `spi_cs_n` all 1, `tx_valid`=0, `tx_data`=0, `data_take`=0, `grant_id`=0, `busy`=0, `rr_ptr`=0, state IDLE.
- A reset asserted in any state returns all of the above on the next edge. Chip select rises immediately and no `data_take` pulses in the reset cycle.
- `req` sampled in IDLE at edge T:
  - `spi_cs_n` low and `busy` high from T+1.
  - `tx_valid` high from T+1+SETUP_CYC.
- Throughput: with `tx_ready` held high, one byte per cycle.
- `data_take` is registered-free (combinational from the handshake) and coincides with the accepting cycle.
- Last handshake at edge T: `tx_valid` low at T+1. Chip select rises the cycle after `tx_done` is sampled in DRAIN.
- Minimum idle between frames: GAP_CYC cycles with all chip selects high, plus one IDLE cycle.
- A `req` that is continuously high from another requester is granted within NREQ−1 frames (fairness).

## Configuration
- `SPI_ARB_PRIO_EN` defined: requester 0 is high priority. In IDLE, if `req[0]`=1 it wins regardless of `rr_ptr`, and `rr_ptr` is not advanced after its frame. Requesters 1..NREQ−1 use round-robin among themselves. Preemption never occurs mid-frame.
- `SPI_ARB_PRIO_EN` undefined: pure round-robin over all NREQ requesters.

## Test plan
- Reset, then `req`=4'b0000 for 20 cycles -> `spi_cs_n`=4'b1111, `busy`=0, `tx_valid`=0 throughout.
- `req[2]`=1, `req_len[2]`=2, `tx_ready`=1, `tx_done` pulsed 8 cycles after the last handshake -> chip select low 1 cycle after the request. Three bytes are accepted on consecutive cycles starting 2 cycles later. `data_take`=4'b0100 three times. Chip select high the cycle after `tx_done`.
- `req`=4'b1111 held, all len=0 -> grants in order 0,1,2,3,0, each separated by ≥3 chip-select-high cycles (4'b1111). With the macro: grants 0,0,0,…
- `tx_ready` toggled 1010… with len=3 -> exactly 4 `data_take` pulses, only on ready-high XFER cycles. `tx_data` follows `req_data` of the owner.
- `req[1]` dropped after its second byte of len=5 -> all 6 bytes still sent and frame completes normally.
- `rst` asserted during XFER with byte_cnt=3 -> next cycle all chip selects 1, `tx_valid`=0, `busy`=0. Next grant starts search at requester 0.
